// File: rtl/usb_rx_timer.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_timer
// Description : USB receive bit timer. Recovers bit timing from D+ line
//               transitions, produces a sample strobe for the downstream shift
//               register, counts bits within a byte, flags completed bytes and
//               detects missing bit-stuffing transitions.
// Ports       : clk           - system clock, rising edge
//               rst           - asynchronous active-high reset
//               d_edge        - one-cycle pulse marking a D+ transition
//               rcving        - high while a packet is being received
//               shift_enable  - sample strobe for the shift register
//               bit_count     - bits shifted in the current byte (0..7)
//               byte_received - one-cycle pulse after the 8th bit of a byte
//               stuff_err     - sticky flag: run without transition too long
// Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_timer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PHASE = 3,
    parameter int MAX_RUN      = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_edge,
    input  logic       rcving,
    output logic       shift_enable,
    output logic [2:0] bit_count,
    output logic       byte_received,
    output logic       stuff_err
);

    localparam int c_PHASE_W = $clog2(CLKS_PER_BIT);
    localparam int c_RUN_W   = $clog2(MAX_RUN + 2);

    localparam logic [c_PHASE_W-1:0] c_SAMPLE   = c_PHASE_W'(SAMPLE_PHASE);
    localparam logic [c_PHASE_W-1:0] c_LAST     = c_PHASE_W'(CLKS_PER_BIT - 1);
    localparam logic [c_RUN_W-1:0]   c_RUN_SAT  = c_RUN_W'(MAX_RUN + 1);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_WAIT_EDGE = 2'd1;
    localparam logic [1:0] c_ST_RUN       = 2'd2;

    logic [1:0]           r_state;
    logic [c_PHASE_W-1:0] r_phase;
    logic [2:0]           r_bit_count;
    logic [c_RUN_W-1:0]   r_run;
    logic                 r_byte_received;
    logic                 r_stuff_err;

    logic                 w_shift;
    logic [c_RUN_W-1:0]   w_run_next;

    // Sample strobe is a pure decode so the shift register sees it in the
    // same cycle the phase counter hits the sample point. Gating with rcving
    // suppresses a strobe in the cycle an abort is signalled.
    assign w_shift = (r_state == c_ST_RUN) && rcving && (r_phase == c_SAMPLE);

    // Run length in bit periods since the last transition. A transition wins
    // over a coincident sample strobe, so the count restarts rather than
    // advancing. Saturation keeps the counter from wrapping back to "clean".
    always_comb begin
        w_run_next = r_run;
        if (d_edge) begin
            w_run_next = '0;
        end else if (w_shift && (r_run != c_RUN_SAT)) begin
            w_run_next = r_run + c_RUN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= c_ST_IDLE;
            r_phase         <= '0;
            r_bit_count     <= '0;
            r_run           <= '0;
            r_byte_received <= 1'b0;
            r_stuff_err     <= 1'b0;
        end else if (!rcving) begin
            // Abort: drop all progress so the next packet starts at bit 0.
            r_state         <= c_ST_IDLE;
            r_phase         <= '0;
            r_bit_count     <= '0;
            r_run           <= '0;
            r_byte_received <= 1'b0;
            r_stuff_err     <= 1'b0;
        end else begin
            r_byte_received <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_state <= c_ST_WAIT_EDGE;
                end
                c_ST_WAIT_EDGE: begin
                    if (d_edge) begin
                        r_state <= c_ST_RUN;
                        r_phase <= '0;
                        r_run   <= '0;
                    end
                end
                c_ST_RUN: begin
                    // Every transition re-aligns the bit clock to the line.
                    if (d_edge || (r_phase == c_LAST)) begin
                        r_phase <= '0;
                    end else begin
                        r_phase <= r_phase + c_PHASE_W'(1);
                    end
                    if (w_shift) begin
                        r_bit_count <= r_bit_count + 3'd1;
                    end
                    r_byte_received <= w_shift && (r_bit_count == 3'd7);
                    r_run           <= w_run_next;
                    // Sticky until abort or reset; timing keeps running.
                    if (w_run_next == c_RUN_SAT) begin
                        r_stuff_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign shift_enable  = w_shift;
    assign bit_count     = r_bit_count;
    assign byte_received = r_byte_received;
    assign stuff_err     = r_stuff_err;

endmodule
`default_nettype wire

// File: doc/usb_rx_timer.md
USB_RX_TIMER -- requirements
Module: usb_rx_timer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 8: system clocks per USB bit period; legal range 4..16.
REQ-002 Parameter SAMPLE_PHASE, default 3: phase count at which a bit is sampled; SHALL satisfy SAMPLE_PHASE < CLKS_PER_BIT.
REQ-003 Parameter MAX_RUN, default 7: maximum bit periods allowed without a line transition.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 d_edge  input  1  one-cycle pulse from the upstream edge detector; marks a D+ line transition.
REQ-007 rcving  input  1  high while a packet is being received; low aborts the block to IDLE.
REQ-008 shift_enable  output  1  one-cycle pulse; downstream shift register samples the line this cycle.
REQ-009 bit_count  output  3  count of bits shifted in the current byte, 0..7.
REQ-010 byte_received  output  1  registered one-cycle pulse; a full byte has been shifted.
REQ-011 stuff_err  output  1  sticky flag; a transition was missing for more than MAX_RUN bit periods.

Function
REQ-012 The FSM SHALL have three states: IDLE, WAIT_EDGE and RUN.
REQ-013 IDLE -> WAIT_EDGE when rcving=1; otherwise hold IDLE.
REQ-014 WAIT_EDGE -> RUN when d_edge=1; on that transition the phase counter loads 0.
REQ-015 Any state -> IDLE on the next clock when rcving=0; phase, bit_count and run counter clear to 0 and stuff_err clears.
REQ-016 In RUN, the phase counter SHALL load 0 on a cycle with d_edge=1; otherwise it increments and wraps from CLKS_PER_BIT-1 to 0.
REQ-017 shift_enable SHALL be a combinational decode: (state==RUN) && rcving && (phase==SAMPLE_PHASE).
REQ-018 shift_enable is therefore first asserted SAMPLE_PHASE+1 cycles after the d_edge cycle that entered RUN.
REQ-019 If d_edge and phase==SAMPLE_PHASE occur in the same cycle, shift_enable SHALL still assert and the phase SHALL still reload 0.
REQ-020 bit_count SHALL increment on every shift_enable and wrap from 7 to 0.
REQ-021 byte_received SHALL assert for exactly one cycle, in the cycle after shift_enable with bit_count==7.
REQ-022 The run counter SHALL clear on d_edge, increment on shift_enable without d_edge, and saturate at MAX_RUN+1.
REQ-023 stuff_err SHALL set on the clock where the run counter reaches MAX_RUN+1 and hold until rcving=0 or rst; timing continues while it is set.
REQ-024 If d_edge and shift_enable coincide, the run counter SHALL clear, with no increment.
REQ-025 d_edge in IDLE SHALL be ignored.

Reset
REQ-026 While rst=1, the state SHALL be IDLE and the phase, bit_count and run counters 0.
REQ-027 While rst=1, shift_enable, byte_received and stuff_err SHALL be 0, independent of clk.
REQ-028 Reset asserted mid-byte SHALL discard all progress, and no byte_received pulse SHALL follow reset release.
REQ-029 After rst falls, the block SHALL require rcving=1 and then a d_edge before any shift_enable.

Verification
REQ-030 Basic timing: rcving=1; one d_edge at cycle T; no further edges -> shift_enable at T+4, T+12, T+20 ... (defaults).
REQ-031 Byte completion: 8 bits as in REQ-030 -> byte_received high only at T+61, one cycle after the 8th shift_enable (T+60); bit_count returns to 0.
REQ-032 Resync: d_edge at T, then d_edge at T+10 -> shift_enable at T+4 and T+14; no pulse at T+12.
REQ-033 Coincidence: d_edge in the same cycle as phase==3 -> shift_enable asserts that cycle, and the next shift_enable follows 4 cycles later.
REQ-034 Stuff error: a single edge followed by 8 bit periods with no edge -> stuff_err rises on the clock after the 8th shift_enable and stays high; dropping rcving clears it within 1 cycle.
REQ-035 Abort/reset: rcving=0 or rst=1 after 5 shifted bits -> bit_count=0 next cycle (immediately for rst) and no byte_received; the next packet starts from bit 0.
